// File: rtl/parity_frame_checker_if.sv
// Bus bundle for parity_frame_checker: frame/bit stimulus in, received word and status out.
// err_count exists only when PARITY_ERR_CNT_EN is defined.
interface parity_frame_checker_if #(
  parameter int DATA_BITS = 8,
  parameter int ERR_CNT_W = 8
);
  logic                 start;
  logic                 odd_par;
  logic                 bit_in;
  logic                 bit_valid;
  logic [DATA_BITS-1:0] data_out;
  logic                 frame_valid;
  logic                 parity_err;
  logic                 busy;
`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count;
`endif

  // Reject widths the checker cannot represent.
  if (DATA_BITS < 2 || DATA_BITS > 32 || ERR_CNT_W < 1) begin : g_bad_param
    $error("parity_frame_checker_if: DATA_BITS must be 2..32 and ERR_CNT_W >= 1");
  end

  modport master (
    output start, odd_par, bit_in, bit_valid,
    input  data_out, frame_valid, parity_err, busy
`ifdef PARITY_ERR_CNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  start, odd_par, bit_in, bit_valid,
    output data_out, frame_valid, parity_err, busy
`ifdef PARITY_ERR_CNT_EN
    , output err_count
`endif
  );
endinterface

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: DATA_BITS data bits (LSB first) followed by one parity bit.
// Even/odd parity selected per frame at start. Optional saturating parity-error
// counter enabled by macro PARITY_ERR_CNT_EN.
module parity_frame_checker #(
  parameter int DATA_BITS = 8,
  parameter int ERR_CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  parity_frame_checker_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  // Reject widths the checker cannot represent.
  if (DATA_BITS < 2 || DATA_BITS > 32 || ERR_CNT_W < 1) begin : g_bad_param
    $error("parity_frame_checker: DATA_BITS must be 2..32 and ERR_CNT_W >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic                 odd_q, odd_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 fv_q, fv_d;
  logic                 par_bad;

  assign par_bad = acc_q ^ bus.bit_in ^ odd_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      odd_q   <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      odd_q   <= odd_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      fv_q    <= fv_d;
    end
  end

  // Next-state logic: start wins over bit_valid in every state (restart/abort).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    odd_d   = odd_q;
    shift_d = shift_q;
    data_d  = data_q;
    perr_d  = perr_q;
    fv_d    = 1'b0;
    if (bus.start) begin
      state_d = DATA;
      cnt_d   = '0;
      acc_d   = 1'b0;
      odd_d   = bus.odd_par;
    end else if (bus.bit_valid) begin
      case (state_q)
        DATA: begin
          // Shift right so the first received bit ends up in bit 0.
          shift_d = {bus.bit_in, shift_q[DATA_BITS-1:1]};
          acc_d   = acc_q ^ bus.bit_in;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          perr_d  = par_bad;
          data_d  = shift_q;
          fv_d    = 1'b1;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out    = data_q;
  assign bus.parity_err  = perr_q;
  assign bus.frame_valid = fv_q;
  assign bus.busy        = (state_q != IDLE);

`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_q, err_d;

  // Saturating count of frames completed with a parity error.
  always_comb begin
    err_d = err_q;
    if (!bus.start && bus.bit_valid && state_q == PARITY && par_bad && err_q != '1) begin
      err_d = err_q + ERR_CNT_W'(1);
    end
  end

  // Error counter register; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_count = err_q;
`endif
endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker: the driver pushes hand-computed
// expectations, the monitor pops and compares on every frame_valid pulse.
module tb_parity_frame_checker;
  localparam int DB = 8;
  localparam int EW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  parity_frame_checker_if #(.DATA_BITS(DB), .ERR_CNT_W(EW)) bus ();
  parity_frame_checker #(.DATA_BITS(DB), .ERR_CNT_W(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [DB-1:0] data;
    logic          perr;
    logic [EW-1:0] err;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks      = 0;
  int            fails       = 0;
  int            frames_exp  = 0;
  int            frames_seen = 0;
  logic [EW-1:0] err_model   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every frame_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      frames_seen++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_frame_valid: got frame data 0x%0h expected no frame", bus.data_out);
      end else begin
        mon_e = sb.pop_front();
        check("data_out", 32'(bus.data_out), 32'(mon_e.data));
        check("parity_err", 32'(bus.parity_err), 32'(mon_e.perr));
`ifdef PARITY_ERR_CNT_EN
        check("err_count", 32'(bus.err_count), 32'(mon_e.err));
`endif
      end
    end
  end

  task automatic send_bit(input logic b, input int gap, input logic exp_busy);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      check("busy_in_gap", 32'(bus.busy), 32'(exp_busy));
    end
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
  endtask

  task automatic do_start(input logic odd, input logic bv);
    bus.start     = 1'b1;
    bus.odd_par   = odd;
    bus.bit_valid = bv;
    bus.bit_in    = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.odd_par   = ~odd;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic odd, input logic pbit,
                            input logic exp_perr, input int maxgap, input logic start_bv);
    exp_t e;
    do_start(odd, start_bv);
    for (int i = 0; i < DB; i++) begin
      send_bit(data[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, 1'b1);
      if (i < DB - 1 || maxgap > 0) check("busy_mid_frame", 32'(bus.busy), 32'd1);
    end
    if (exp_perr && err_model != '1) err_model = err_model + EW'(1);
    e.data = data;
    e.perr = exp_perr;
    e.err  = err_model;
    sb.push_back(e);
    frames_exp++;
    send_bit(pbit, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, 1'b1);
    check("busy_after_parity", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before timeout");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.odd_par   = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_parity_err", 32'(bus.parity_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0xA5 even, parity 0 -> ok; parity 1 -> error
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    // 0x01 odd parity 0 -> ok; even parity 0 -> error
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    // 0x3C with random gaps 0..5
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 5, 1'b0);
    // start with bit_valid in IDLE: bit not consumed; 0x81 even parity 0 -> ok
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    // Abort after 4 bits, restart edge carries a bit that must be dropped
    do_start(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    // Five bad-parity frames: counter saturates at 3
    for (int k = 0; k < 5; k++) send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    repeat (2) @(posedge clk); #1;
`ifdef PARITY_ERR_CNT_EN
    check("err_count_saturated", 32'(bus.err_count), 32'd3);
`endif

    // Reset after 3 bits: no frame_valid, all outputs cleared
    do_start(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data_out", 32'(bus.data_out), 32'd0);
    check("midrst_parity_err", 32'(bus.parity_err), 32'd1 - 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_frame_valid", 32'(bus.frame_valid), 32'd0);
`ifdef PARITY_ERR_CNT_EN
    check("midrst_err_count", 32'(bus.err_count), 32'd0);
`endif
    err_model = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Bits without start are ignored in IDLE
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 1'b0);
    check("idle_ignores_bits", 32'(bus.busy), 32'd0);

    // 0xFF odd parity 1 -> ok
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    repeat (3) @(posedge clk); #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("frame_count", 32'(frames_seen), 32'(frames_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
